// File: rtl/spawn_ctrl_pkg.sv
// Shared types and sizing helpers for the staggered pipe launch sequencer.
package spawn_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    P1   = 2'd1,
    P2   = 2'd2,
    DONE = 2'd3
  } spawn_state_t;

  localparam int NUM_PIPES = 3;

  // Counter must hold SPAWN_SPEED-1; never narrower than one bit.
  function automatic int cnt_width(input int speed);
    int w;
    w = $clog2(speed + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/spawn_timer.sv
// Loadable down-counter with a zero flag; load has priority over decrement.
module spawn_timer #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/spawn_ctrl_fsm.sv
// Launches pipe 1, 2 and 3 on a start request, SPAWN_SPEED clocks apart.
// state | meaning
// IDLE  | waiting for i_Start, all pipe enables low
// P1    | pipe 1 running, timing gap to pipe 2
// P2    | pipes 1-2 running, timing gap to pipe 3
// DONE  | all pipes running until reset
module spawn_ctrl_fsm
  import spawn_ctrl_pkg::*;
#(
  parameter int SPAWN_SPEED = 25_000_000
) (
  input  logic i_Clk,
  input  logic i_Reset,
  input  logic i_Start,
  output logic o_Pipe1_Start,
  output logic o_Pipe2_Start,
  output logic o_Pipe3_Start
);

  localparam int            CW     = cnt_width(SPAWN_SPEED);
  localparam logic [CW-1:0] RELOAD = CW'(SPAWN_SPEED - 1);

  spawn_state_t         state_q, state_d;
  logic [NUM_PIPES-1:0] pipes_q, pipes_d;
  logic                 load, en, zero;

  spawn_timer #(.W(CW)) u_timer (
    .clk_i      (i_Clk),
    .rst_n_i    (i_Reset),
    .load_i     (load),
    .load_val_i (RELOAD),
    .en_i       (en),
    .zero_o     (zero)
  );

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    en      = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_Start) begin
          state_d = P1;
          load    = 1'b1;
        end
      end
      P1: begin
        if (zero) begin
          state_d = P2;
          load    = 1'b1;
        end else begin
          en = 1'b1;
        end
      end
      P2: begin
        if (zero) begin
          state_d = DONE;
        end else begin
          en = 1'b1;
        end
      end
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Enables are a registered decode of the next state, so they change with the state.
  always_comb begin
    pipes_d    = '0;
    pipes_d[0] = (state_d != IDLE);
    pipes_d[1] = (state_d == P2) || (state_d == DONE);
    pipes_d[2] = (state_d == DONE);
  end

  always_ff @(posedge i_Clk or negedge i_Reset) begin
    if (!i_Reset) begin
      state_q <= IDLE;
      pipes_q <= '0;
    end else begin
      state_q <= state_d;
      pipes_q <= pipes_d;
    end
  end

  assign o_Pipe1_Start = pipes_q[0];
  assign o_Pipe2_Start = pipes_q[1];
  assign o_Pipe3_Start = pipes_q[2];

endmodule

// File: tb/tb_spawn_ctrl_fsm.sv
// Bench for spawn_ctrl_fsm: SPAWN_SPEED=3 and SPAWN_SPEED=1 instances share stimulus.
module tb_spawn_ctrl_fsm;

  localparam int S_A = 3;
  localparam int S_B = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'bx;
  logic a1, a2, a3, b1, b2, b3;

  int vectors = 0;
  int miscompares = 0;

  // Launch-time model: a pipe n (0-based) is on once n*S clocks have passed since launch.
  int cyc = 0;
  int k_launch = 0;
  bit launched = 1'b0;

  always #5 clk = ~clk;

  spawn_ctrl_fsm #(.SPAWN_SPEED(S_A)) dut_a (
    .i_Clk(clk), .i_Reset(rst_n), .i_Start(start),
    .o_Pipe1_Start(a1), .o_Pipe2_Start(a2), .o_Pipe3_Start(a3)
  );

  spawn_ctrl_fsm #(.SPAWN_SPEED(S_B)) dut_b (
    .i_Clk(clk), .i_Reset(rst_n), .i_Start(start),
    .o_Pipe1_Start(b1), .o_Pipe2_Start(b2), .o_Pipe3_Start(b3)
  );

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n !== 1'b1) begin
      launched <= 1'b0;
    end else if (!launched && (start === 1'b1)) begin
      launched <= 1'b1;
      k_launch <= cyc + 1;
    end
  end

  function automatic logic [2:0] model(input int s);
    logic [2:0] e;
    e = 3'b000;
    if (rst_n === 1'b1 && launched) begin
      for (int n = 0; n < 3; n++) e[n] = ((cyc - k_launch) >= n * s);
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // Every-cycle comparison against the model plus the ordering invariant.
  always @(negedge clk) begin
    chk("model_s3", {a3, a2, a1}, model(S_A));
    chk("model_s1", {b3, b2, b1}, model(S_B));
    chk("order_s3", {1'b0, (a3 & ~a2), (a2 & ~a1)}, 3'b000);
    chk("order_s1", {1'b0, (b3 & ~b2), (b2 & ~b1)}, 3'b000);
  end

  // Hand-computed output words {pipe3,pipe2,pipe1} after edge k+i.
  logic [2:0] lit_a [0:7];
  logic [2:0] lit_b [0:7];

  task automatic step();
    @(posedge clk);
    #3;
  endtask

  task automatic lit_check(input string tag, input int i);
    chk({tag, "_s3"}, {a3, a2, a1}, lit_a[i]);
    chk({tag, "_s1"}, {b3, b2, b1}, lit_b[i]);
  endtask

  initial begin
    lit_a[0] = 3'b001; lit_a[1] = 3'b001; lit_a[2] = 3'b001; lit_a[3] = 3'b011;
    lit_a[4] = 3'b011; lit_a[5] = 3'b011; lit_a[6] = 3'b111; lit_a[7] = 3'b111;
    lit_b[0] = 3'b001; lit_b[1] = 3'b011; lit_b[2] = 3'b111; lit_b[3] = 3'b111;
    lit_b[4] = 3'b111; lit_b[5] = 3'b111; lit_b[6] = 3'b111; lit_b[7] = 3'b111;

    // 1: reset held with X then 0 on start
    for (int i = 0; i < 5; i++) begin
      step();
      if (i == 2) start = 1'b0;
      chk("reset_s3", {a3, a2, a1}, 3'b000);
      chk("reset_s1", {b3, b2, b1}, 3'b000);
    end

    // 2: launch and hold start high, then run 30 clocks
    rst_n = 1'b1;
    step();
    start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      lit_check("launch", i);
    end
    for (int i = 0; i < 30; i++) step();
    chk("hold_s3", {a3, a2, a1}, 3'b111);
    chk("hold_s1", {b3, b2, b1}, 3'b111);

    // 3: start dropped after the launch edge
    rst_n = 1'b0;
    start = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
    start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      lit_check("drop", i);
      if (i == 0) start = 1'b0;
    end
    for (int i = 0; i < 10; i++) step();
    chk("drop_hold_s3", {a3, a2, a1}, 3'b111);

    // 4: reset mid-sequence clears at once, then full restart
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
    start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      lit_check("pre_abort", i);
    end
    rst_n = 1'b0;
    #1;
    chk("abort_s3", {a3, a2, a1}, 3'b000);
    chk("abort_s1", {b3, b2, b1}, 3'b000);
    step(); step();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      lit_check("restart", i);
    end

    // 5: no start (including X) after reset keeps everything idle
    rst_n = 1'b0;
    start = 1'b0;
    step(); step();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      start = (i < 3) ? 1'bx : 1'b0;
      step();
      chk("idle_s3", {a3, a2, a1}, 3'b000);
      chk("idle_s1", {b3, b2, b1}, 3'b000);
    end

    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
